// File: rtl/edge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : edge_pkg                                                          |
// | Purpose : Shared geometry constants and the row-feeder state encoding for   |
// |           the blur edge pipeline.                                           |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package edge_pkg;

  localparam int PIXEL_W       = 8;   // bits per pixel
  localparam int TILE_W        = 16;  // strip width in pixels
  localparam int WIN_W         = 20;  // pixels presented to the blur stage
  localparam int STAGE_W       = 24;  // pixels covered by one row's fetch
  localparam int WORDS_PER_ROW = 6;   // 32-bit memory words per row fetch

  // Pixels of the fetched span that fall outside the presented window, per side.
  localparam int EDGE_PAD = (STAGE_W - WIN_W) / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } feeder_state_t;

endpackage : edge_pkg
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : flex_counter                                                      |
// | Purpose : Free-running up counter with synchronous clear and count enable.  |
// |           Clear has priority over enable. Wraps naturally at 2^N.           |
// | Ports   : clk, n_rst (async, active-low), clear, count_enable -> count_out  |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = count_q + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule : flex_counter
`default_nettype wire

// File: rtl/blur_row_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : blur_row_feeder                                                   |
// | Purpose : Producer side of the blur row handoff. Walks the image in         |
// |           16-pixel vertical strips, top to bottom, fetches each row's       |
// |           24-pixel span (cols c-4..c+19) from image memory and presents the |
// |           20-pixel window (cols c-2..c+17) on blur_in. The next row is      |
// |           prefetched while the blur stage works on the current one.         |
// | Config  : EDGE_REPLICATE_EN - when defined, columns left of the image take  |
// |           the value of col 0 and columns right of it take col IMG_W-1;      |
// |           otherwise they read as zero.                                      |
// | Ports   : clk, n_rst (async, active-low), start                             |
// |           mem_req/mem_addr/mem_rdata/mem_ack : image memory read port       |
// |           blur_final    : blur controller finished its current row          |
// |           anchor_moving : a staged row is waiting for handoff               |
// |           anchor_x/y    : row index / strip column of last handed-off row   |
// |           blur_in       : 20-pixel window, [0] = col c-2                    |
// |           frame_done    : one-cycle pulse after the last row is consumed    |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module blur_row_feeder
  import edge_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 0
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             start,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [31:0]                      mem_rdata,
  input  logic                             mem_ack,
  input  logic                             blur_final,
  output logic                             anchor_moving,
  output logic [31:0]                      anchor_x,
  output logic [31:0]                      anchor_y,
  output logic [WIN_W-1:0][PIXEL_W-1:0]    blur_in,
  output logic                             frame_done
);

  feeder_state_t state_q, state_d;
  logic [31:0]   r_q, r_d;
  logic [31:0]   c_q, c_d;
  logic [31:0]   anchor_x_q, anchor_x_d;
  logic [31:0]   anchor_y_q, anchor_y_d;
  logic          busy_q, busy_d;
  logic          mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic          anchor_moving_q, anchor_moving_d;
  logic          frame_done_q, frame_done_d;
  logic [WIN_W-1:0][PIXEL_W-1:0] win_q, win_d;

  logic [3:0]    k;
  logic          cnt_clear;
  logic          cnt_en;

  logic          left_edge;
  logic          right_edge;
  logic          last_word;
  logic          skip_word;
  logic          do_ack;
  logic          do_skip;
  logic          handoff;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          rep_l;
  logic          rep_r;
  logic [31:0]   pix_idx;
  logic [PIXEL_W-1:0] win_nxt [WIN_W];

  // Word index k within the current row's fetch.
  flex_counter #(
    .NUM_CNT_BITS (4)
  ) u_k_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .count_out    (k)
  );

  // Fetch bookkeeping.
  always_comb begin
    left_edge  = (c_q == 32'd0);
    right_edge = ((c_q + 32'(TILE_W)) == 32'(IMG_W));
    last_word  = (k == 4'(WORDS_PER_ROW - 1));
    // Only the outermost words can lie wholly outside the image.
    skip_word  = ((k == 4'd0) && left_edge) || (last_word && right_edge);
    do_ack     = (state_q == FETCH) && mem_req_q && mem_ack;
    do_skip    = (state_q == FETCH) && !mem_req_q && skip_word;
    // Linear pixel index of the first column of word k: r*IMG_W + c - 4 + 4k.
    pix_idx    = r_q * 32'(IMG_W) + c_q + {26'd0, k, 2'b00} - 32'd4;
    handoff    = (state_q == READY) && anchor_moving_q && (!busy_q || blur_final);
    wr_data    = do_ack ? mem_rdata : 32'd0;
`ifdef EDGE_REPLICATE_EN
    // Skipped words are left alone and filled from the neighbouring word of
    // the same row when it arrives: word 1 holds col 0, word 4 holds IMG_W-1.
    wr_en      = do_ack;
    rep_l      = do_ack && (k == 4'd1) && left_edge;
    rep_r      = do_ack && (k == 4'(WORDS_PER_ROW - 2)) && right_edge;
`else
    wr_en      = do_ack || do_skip;
    rep_l      = 1'b0;
    rep_r      = 1'b0;
`endif
  end

  // Only the 20 presented pixels are stored; the two outer pixels on each
  // side of the fetched span never reach blur_in so their writes are dropped.
  for (genvar gi = 0; gi < WIN_W; gi++) begin : g_win
    localparam int S = gi + EDGE_PAD;   // position within the fetched span
    localparam int K = S / 4;           // word holding this pixel
    localparam int B = S % 4;           // byte lane within that word
    logic [PIXEL_W-1:0] pix_new;

    always_comb begin
      pix_new = win_q[gi];
      if (wr_en && (k == 4'(K))) begin
        pix_new = wr_data[B*PIXEL_W +: PIXEL_W];
      end else if (rep_l && (K == 0)) begin
        pix_new = mem_rdata[PIXEL_W-1:0];
      end else if (rep_r && (K == WORDS_PER_ROW - 1)) begin
        pix_new = mem_rdata[31 -: PIXEL_W];
      end
    end

    assign win_nxt[gi] = pix_new;
  end

  // Next-state and output logic.
  always_comb begin
    state_d         = state_q;
    r_d             = r_q;
    c_d             = c_q;
    anchor_x_d      = anchor_x_q;
    anchor_y_d      = anchor_y_q;
    busy_d          = busy_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    anchor_moving_d = anchor_moving_q;
    frame_done_d    = 1'b0;
    cnt_clear       = 1'b0;
    cnt_en          = 1'b0;
    for (int i = 0; i < WIN_W; i++) begin
      win_d[i] = win_nxt[i];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          r_d       = 32'd0;
          c_d       = 32'd0;
          cnt_clear = 1'b1;
        end
      end

      FETCH: begin
        if (do_ack || do_skip) begin
          cnt_en = 1'b1;
          if (do_ack) begin
            mem_req_d = 1'b0;
          end
          if (last_word) begin
            state_d         = READY;
            anchor_moving_d = 1'b1;
          end
        end else if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = ADDR_W'(32'(BASE_ADDR) + (pix_idx >> 2));
        end
        // The blur stage may finish the previous row while we prefetch.
        if (blur_final) begin
          busy_d = 1'b0;
        end
      end

      READY: begin
        if (handoff) begin
          anchor_x_d      = r_q;
          anchor_y_d      = c_q;
          busy_d          = 1'b1;
          anchor_moving_d = 1'b0;
          if (r_q == 32'(IMG_H - 1)) begin
            r_d = 32'd0;
            c_d = c_q + 32'(TILE_W);
          end else begin
            r_d = r_q + 32'd1;
          end
          if ((r_q == 32'(IMG_H - 1)) && right_edge) begin
            state_d = DRAIN;
          end else begin
            state_d   = FETCH;
            cnt_clear = 1'b1;
          end
        end else if (blur_final) begin
          busy_d = 1'b0;
        end
      end

      DRAIN: begin
        if (blur_final) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      r_q             <= '0;
      c_q             <= '0;
      anchor_x_q      <= '0;
      anchor_y_q      <= '0;
      busy_q          <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      anchor_moving_q <= 1'b0;
      frame_done_q    <= 1'b0;
      win_q           <= '0;
    end else begin
      state_q         <= state_d;
      r_q             <= r_d;
      c_q             <= c_d;
      anchor_x_q      <= anchor_x_d;
      anchor_y_q      <= anchor_y_d;
      busy_q          <= busy_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
      anchor_moving_q <= anchor_moving_d;
      frame_done_q    <= frame_done_d;
      win_q           <= win_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign anchor_moving = anchor_moving_q;
  assign anchor_x      = anchor_x_q;
  assign anchor_y      = anchor_y_q;
  assign blur_in       = win_q;
  assign frame_done    = frame_done_q;

endmodule : blur_row_feeder
`default_nettype wire

// File: tb/tb_blur_row_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_blur_row_feeder                                                |
// | Purpose : Scoreboard bench for blur_row_feeder on a 32x4 image. Expected    |
// |           request addresses and row windows are queued when a frame is      |
// |           started; independent monitors pop and compare as the DUT issues   |
// |           requests and stages rows. Honours EDGE_REPLICATE_EN.              |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_blur_row_feeder;
  import edge_pkg::*;

  localparam int IMG_W     = 32;
  localparam int IMG_H     = 4;
  localparam int ADDR_W    = 18;
  localparam int BASE_ADDR = 0;
  localparam int ROWS      = (IMG_W / TILE_W) * IMG_H;

  typedef logic [WIN_W-1:0][PIXEL_W-1:0] win_t;
  typedef struct {
    int   r;
    int   c;
    win_t win;
  } row_exp_t;

  logic              clk;
  logic              n_rst;
  logic              start;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              blur_final;
  logic              anchor_moving;
  logic [31:0]       anchor_x;
  logic [31:0]       anchor_y;
  win_t              blur_in;
  logic              frame_done;

  int       errors = 0;
  int       checks = 0;
  int       exp_addr_q[$];
  row_exp_t exp_row_q[$];
  int       ack_mode = 1;    // fixed ack delay, or -1 for random 0..7
  int       wait_cnt = 1;
  int       fd_count = 0;

  blur_row_feeder #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .blur_final    (blur_final),
    .anchor_moving (anchor_moving),
    .anchor_x      (anchor_x),
    .anchor_y      (anchor_y),
    .blur_in       (blur_in),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image content: pixel at linear index idx.
  function automatic logic [7:0] pixval(input int idx);
    return 8'(idx * 13 + 5);
  endfunction

  function automatic logic [31:0] mem_word(input int a);
    return {pixval(4*a+3), pixval(4*a+2), pixval(4*a+1), pixval(4*a)};
  endfunction

  function automatic logic [7:0] exp_pix(input int r, input int col);
    if (col < 0) begin
`ifdef EDGE_REPLICATE_EN
      return pixval(r*IMG_W);
`else
      return 8'd0;
`endif
    end
    if (col >= IMG_W) begin
`ifdef EDGE_REPLICATE_EN
      return pixval(r*IMG_W + IMG_W - 1);
`else
      return 8'd0;
`endif
    end
    return pixval(r*IMG_W + col);
  endfunction

  function automatic win_t exp_win(input int r, input int c);
    win_t w;
    for (int i = 0; i < WIN_W; i++) w[i] = exp_pix(r, c - 2 + i);
    return w;
  endfunction

  task automatic check_val(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_bf();
    blur_final = 1'b1;
    tick();
    blur_final = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_am(input logic lvl, input string what);
    int n = 0;
    while (anchor_moving !== lvl && n < 600) begin
      tick();
      n++;
    end
    if (anchor_moving !== lvl) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: anchor_moving=%b required=%b", what, anchor_moving, lvl);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    if (mem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout_req: mem_req=%b required=1", mem_req);
    end
  endtask

  // Hand-derived request sequence: strip 0 row r reads words 8r..8r+4 (left
  // word skipped), strip 1 row r reads 8r+3..8r+7 (right word skipped).
  task automatic push_frame();
    row_exp_t e;
    for (int s = 0; s < IMG_W / TILE_W; s++) begin
      for (int r = 0; r < IMG_H; r++) begin
        for (int k = 0; k < 5; k++) exp_addr_q.push_back(BASE_ADDR + 8*r + k + 3*s);
        e.r   = r;
        e.c   = TILE_W * s;
        e.win = exp_win(r, TILE_W * s);
        exp_row_q.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input int hold1, input int stop_at);
    logic [31:0] w0;
    push_frame();
    fd_count = 0;
    pulse_start();
    for (int n = 0; n < ROWS; n++) begin
      if (n == stop_at) begin
        wait_req();
        return;
      end
      if (n == 2) pulse_bf();      // blur finishes while row 2 is still fetching
      if (n == 3) pulse_start();   // must be ignored mid-frame
      wait_am(1'b1, "ready");
      if (n == 0) begin
        w0 = mem_word(0);
        check_val("row0_col0", blur_in[2], w0[7:0]);
        check_val("row0_left_edge", blur_in[0], exp_pix(0, -2));
      end
      if (n == IMG_H) begin
        check_val("strip1_right_edge", blur_in[19], exp_pix(0, IMG_W + 1));
      end
      if (n != 0 && n != 2) begin
        repeat (n == 1 ? hold1 : 2) tick();
        check_val("am_held", anchor_moving, 1);
        pulse_bf();
      end
      wait_am(1'b0, "handoff");
    end
    repeat (3) tick();
    check_val("no_early_done", fd_count, 0);
    pulse_bf();
    repeat (3) tick();
    check_val("frame_done_once", fd_count, 1);
    check_val("idle_no_req", mem_req, 0);
    check_val("addr_q_empty", exp_addr_q.size(), 0);
    check_val("row_q_empty", exp_row_q.size(), 0);
  endtask

  // Memory responder.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (n_rst && mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(int'(mem_addr));
          wait_cnt  = (ack_mode < 0) ? int'($urandom_range(7, 0)) : ack_mode;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Request monitor.
  initial begin
    logic              prev_req;
    logic              prev_ack;
    logic [ADDR_W-1:0] req_addr;
    int                e;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    req_addr = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (mem_req && (!prev_req || prev_ack)) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: addr=%0d required=none", mem_addr);
          end else begin
            e = exp_addr_q.pop_front();
            check_val("req_addr", mem_addr, e);
          end
          req_addr = mem_addr;
        end
        if (mem_req && mem_ack) check_val("addr_stable", mem_addr, req_addr);
        prev_req = mem_req;
        prev_ack = mem_ack;
      end
    end
  end

  // Row/window monitor.
  initial begin
    logic     prev_am;
    logic     have_cur;
    row_exp_t cur;
    prev_am  = 1'b0;
    have_cur = 1'b0;
    cur.r = 0; cur.c = 0; cur.win = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_am  = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (frame_done) fd_count++;
        if (anchor_moving && !prev_am) begin
          if (exp_row_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: anchor_moving=1 required=0");
          end else begin
            cur      = exp_row_q.pop_front();
            have_cur = 1'b1;
            check_val("row_window", blur_in, cur.win);
          end
        end
        if (!anchor_moving && prev_am && have_cur) begin
          check_val("anchor_x", anchor_x, cur.r);
          check_val("anchor_y", anchor_y, cur.c);
          check_val("window_stable", blur_in, cur.win);
        end
        prev_am = anchor_moving;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Stimulus.
  initial begin
    logic [84:0] snap_ctrl;
    win_t        snap_win;
    logic        any_req;
    n_rst      = 1'b0;
    start      = 1'b0;
    blur_final = 1'b0;
    repeat (3) tick();
    check_val("reset_ctrl", {mem_req, mem_addr, anchor_moving, anchor_x, anchor_y, frame_done}, '0);
    check_val("reset_win", blur_in, '0);
    n_rst = 1'b1;
    tick();

    // blur_final while idle does nothing.
    pulse_bf();
    repeat (3) tick();
    check_val("idle_bf_ctrl", {mem_req, anchor_moving, frame_done}, '0);

    // Frame 1: fixed 1-cycle ack, 20-cycle stall on row 1.
    ack_mode = 1;
    run_frame(20, ROWS);
    snap_ctrl = {mem_req, mem_addr, anchor_moving, anchor_x, anchor_y, frame_done};
    snap_win  = blur_in;
    pulse_bf();
    repeat (3) tick();
    check_val("post_frame_ctrl", {mem_req, mem_addr, anchor_moving, anchor_x, anchor_y, frame_done}, snap_ctrl);
    check_val("post_frame_win", blur_in, snap_win);
    check_val("post_frame_done_cnt", fd_count, 1);

    // Frame 2: random ack delay.
    ack_mode = -1;
    run_frame(3, ROWS);

    // Frame 3: reset in the middle of the second strip's fetch.
    ack_mode = 1;
    run_frame(3, IMG_H + 1);
    #2;
    n_rst = 1'b0;
    #1;
    check_val("midrst_ctrl", {mem_req, mem_addr, anchor_moving, anchor_x, anchor_y, frame_done}, '0);
    check_val("midrst_win", blur_in, '0);
    exp_addr_q.delete();
    exp_row_q.delete();
    wait_cnt = 1;
    repeat (3) tick();
    n_rst = 1'b1;
    any_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req) any_req = 1'b1;
    end
    check_val("no_req_after_rst", any_req, 0);

    // Frame 4: fresh frame after reset.
    run_frame(3, ROWS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_blur_row_feeder
`default_nettype wire
